// File: rtl/sram_like_resp_pkg.sv
// Shared types and constants for the SRAM-like responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_like_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int MAX_LATENCY = 15;

  // One accepted-but-unanswered transaction; cnt counts down to its data_ok cycle
  typedef struct packed {
    logic        is_rd;
    logic [3:0]  cnt;
    logic [31:0] data;
  } resp_entry_t;

endpackage

// File: rtl/sram_like_resp_if.sv
// SRAM-like req/addr_ok/data_ok bus between a core port and its memory.
// Latency: n/a (wires only).
// Backpressure: addr_ok throttles requests; data_ok is never throttled.
interface sram_like_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_resp_fifo.sv
// In-order queue of outstanding responses, each with its own countdown to retirement.
// Latency: push visible at head the cycle after the push edge; pop takes effect at the edge.
// Backpressure: caller must not push when full nor pop when empty.
module resp_fifo
  import sram_like_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  resp_entry_t push_entry,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output resp_entry_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  resp_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  // Count every stored entry down towards zero, then apply push/pop.
  // Free slots also count down, which is harmless: a push overwrites the whole slot.
  always_comb begin
    ent_d    = ent_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].cnt != 4'd0) begin
        ent_d[i].cnt = ent_q[i].cnt - 4'd1;
      end
    end
    if (push) begin
      ent_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State register; reset drops all in-flight entries
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ent_q    <= ent_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = ent_q[rd_ptr_q];

endmodule

// File: rtl/sram_like_resp.sv
// SRAM-like responder: word array with byte-lane writes, in-order fixed-latency responses.
// Latency: data_ok exactly LATENCY cycles after accept; at most one response per cycle.
// Backpressure: addr_ok drops when DEPTH responses are outstanding or during the post-accept gap.
module sram_like_resp
  import sram_like_pkg::*;
#(
  parameter int MEM_AW      = 10,
  parameter int LATENCY     = 2,
  parameter int DEPTH       = 4,
  parameter int ADDR_OK_GAP = 0
) (
  input  logic     clk,
  input  logic     reset,
  sram_like_if.slave bus
);

  localparam int WORDS = 2 ** MEM_AW;
  localparam int GAP_W = (ADDR_OK_GAP < 1) ? 1 : $clog2(ADDR_OK_GAP + 1);
  localparam logic [3:0]       CNT_INIT = 4'(LATENCY - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(ADDR_OK_GAP);

  logic [31:0]       mem_q [WORDS];
  logic [MEM_AW-1:0] idx;
  logic [31:0]       rd_word;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              addr_ok;
  logic              accept;
  logic              retire;
  logic              full;
  logic              empty;
  resp_entry_t       push_entry;
  resp_entry_t       head;

  // Upper address bits alias and the two byte-offset bits are ignored; size is informational only
  logic unused_ok;
  assign unused_ok = ^{bus.size, bus.addr[31:MEM_AW+2], bus.addr[1:0]};

  assign idx     = bus.addr[MEM_AW+1:2];
  assign rd_word = mem_q[idx];

  // Handshake: accept window from state only, retirement when the head countdown expires
  always_comb begin
    addr_ok          = !reset && !full && (gap_q == '0);
    accept           = bus.req && addr_ok;
    retire           = !reset && !empty && (head.cnt == 4'd0);
    push_entry.is_rd = !bus.wr;
    push_entry.cnt   = CNT_INIT;
    push_entry.data  = bus.wr ? 32'd0 : rd_word;
    bus.addr_ok      = addr_ok;
    bus.data_ok      = retire;
    bus.rdata        = (retire && head.is_rd) ? head.data : 32'd0;
  end

  // Gap counter: reload on every accept, otherwise count down to zero
  always_comb begin
    gap_d = gap_q;
    if (accept) begin
      gap_d = GAP_INIT;
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end
  end

  // Gap counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end

  // Word array: byte-lane writes on accept; contents survive reset by design
  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) begin
          mem_q[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  resp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (retire),
    .full       (full),
    .empty      (empty),
    .head       (head)
  );

endmodule

// File: tb/tb_sram_like_resp.sv
// Bench for sram_like_resp: four parameterisations driven by directed vectors.
// Expected responses are queued at accept time and checked by an independent monitor.
// Every wait is bounded; the run always ends with one summary line.
module tb_sram_like_resp;
  import sram_like_pkg::*;

  localparam int NI = 4;
  localparam int LAT [NI] = '{2, 8, 3, 4};

  typedef struct {
    int          cyc;
    logic [31:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        req_s   [NI];
  logic        wr_s    [NI];
  logic [3:0]  strb_s  [NI];
  logic [31:0] addr_s  [NI];
  logic [31:0] wdata_s [NI];
  logic        aok_s   [NI];
  logic        dok_s   [NI];
  logic [31:0] rdat_s  [NI];

  exp_t exp_q [NI][$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_like_if bus [NI] ();

  for (genvar g = 0; g < NI; g++) begin : g_conn
    assign bus[g].req   = req_s[g];
    assign bus[g].wr    = wr_s[g];
    assign bus[g].size  = SZ_WORD;
    assign bus[g].wstrb = strb_s[g];
    assign bus[g].addr  = addr_s[g];
    assign bus[g].wdata = wdata_s[g];
    assign aok_s[g]     = bus[g].addr_ok;
    assign dok_s[g]     = bus[g].data_ok;
    assign rdat_s[g]    = bus[g].rdata;
  end

  sram_like_resp #(.MEM_AW(10), .LATENCY(2), .DEPTH(4), .ADDR_OK_GAP(0))
    u_a (.clk(clk), .reset(rst), .bus(bus[0]));
  sram_like_resp #(.MEM_AW(10), .LATENCY(8), .DEPTH(4), .ADDR_OK_GAP(0))
    u_b (.clk(clk), .reset(rst), .bus(bus[1]));
  sram_like_resp #(.MEM_AW(10), .LATENCY(3), .DEPTH(4), .ADDR_OK_GAP(2))
    u_c (.clk(clk), .reset(rst), .bus(bus[2]));
  sram_like_resp #(.MEM_AW(10), .LATENCY(4), .DEPTH(4), .ADDR_OK_GAP(0))
    u_d (.clk(clk), .reset(rst), .bus(bus[3]));

  // Monitor: every data_ok must match the oldest queued expectation in cycle and data
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (dok_s[i]) begin
        if (exp_q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp inst%0d cyc %0d rdata %h, no response was due", i, cyc, rdat_s[i]);
        end else begin
          mon_e = exp_q[i].pop_front();
          checks++;
          if (mon_e.cyc != cyc) begin
            errors++;
            $display("FAIL resp_cycle inst%0d got data_ok at %0d, due at %0d", i, cyc, mon_e.cyc);
          end
          checks++;
          if (rdat_s[i] !== mon_e.rd) begin
            errors++;
            $display("FAIL resp_rdata inst%0d cyc %0d got %h, want %h", i, cyc, rdat_s[i], mon_e.rd);
          end
        end
      end else if (exp_q[i].size() != 0 && exp_q[i][0].cyc < cyc) begin
        mon_e = exp_q[i].pop_front();
        checks++;
        errors++;
        $display("FAIL missing_resp inst%0d due at %0d, none by %0d", i, mon_e.cyc, cyc);
      end
    end
  end

  task automatic chk_int(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d, want %0d", name, act, want);
    end
  endtask

  // Present one request, hold it until accepted, queue its expected response
  task automatic issue(input int i, input bit w, input logic [3:0] strb,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input bit track, output int acc_cyc);
    bit done = 1'b0;
    int waited = 0;
    acc_cyc     = -1;
    req_s[i]    = 1'b1;
    wr_s[i]     = w;
    strb_s[i]   = strb;
    addr_s[i]   = a;
    wdata_s[i]  = d;
    while (!done && waited < 64) begin
      @(negedge clk);
      if (aok_s[i]) begin
        acc_cyc = cyc;
        done    = 1'b1;
        if (track) exp_q[i].push_back('{cyc + LAT[i], w ? 32'd0 : exp_rd});
      end
      @(posedge clk);
      #1;
      waited++;
    end
    req_s[i] = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout inst%0d addr %h, not accepted in %0d cycles", i, a, waited);
    end
  endtask

  task automatic wait_drain(input int i);
    int n = 0;
    while (exp_q[i].size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (exp_q[i].size() != 0) begin
      errors++;
      $display("FAIL drain_timeout inst%0d still %0d responses due, want 0", i, exp_q[i].size());
    end
  endtask

  initial begin
    int acc [5];
    int a0, a1;
    for (int i = 0; i < NI; i++) begin
      req_s[i] = 1'b1; wr_s[i] = 1'b0; strb_s[i] = 4'hF;
      addr_s[i] = 32'h0; wdata_s[i] = 32'h0;
    end

    // 1: reset held 3 cycles with req high: outputs quiet, nothing accepted
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        chk_int("reset_addr_ok", int'(aok_s[i]), 0);
        chk_int("reset_data_ok", int'(dok_s[i]), 0);
        chk_int("reset_rdata", int'(rdat_s[i]), 0);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) req_s[i] = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 2: write then read back-to-back on LATENCY=2
    issue(0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 32'h0, 1'b1, a0);
    issue(0, 1'b0, 4'h0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1, a1);
    chk_int("b2b_accept", a1 - a0, 1);
    wait_drain(0);

    // 3: partial write, zero-strobe write, address aliasing
    issue(0, 1'b1, 4'hF, 32'h200, 32'h11223344, 32'h0, 1'b1, a0);
    issue(0, 1'b1, 4'b0010, 32'h200, 32'h0000AB00, 32'h0, 1'b1, a0);
    issue(0, 1'b0, 4'h0, 32'h200, 32'h0, 32'h1122AB44, 1'b1, a0);
    issue(0, 1'b1, 4'h0, 32'h200, 32'hFFFFFFFF, 32'h0, 1'b1, a0);
    issue(0, 1'b0, 4'h0, 32'h200, 32'h0, 32'h1122AB44, 1'b1, a0);
    issue(0, 1'b1, 4'hF, 32'h1008, 32'h55AA55AA, 32'h0, 1'b1, a0);
    issue(0, 1'b0, 4'h0, 32'h000B, 32'h0, 32'h55AA55AA, 1'b1, a0);
    wait_drain(0);

    // 4: DEPTH=4, LATENCY=8, reads held: 4 accepts, stall until first data_ok passes, then accept
    for (int k = 0; k < 5; k++)
      issue(1, 1'b1, 4'hF, 32'(4 * k), 32'hB000_0000 + 32'(k), 32'h0, 1'b1, a0);
    wait_drain(1);
    for (int k = 0; k < 5; k++)
      issue(1, 1'b0, 4'h0, 32'(4 * k), 32'h0, 32'hB000_0000 + 32'(k), 1'b1, acc[k]);
    chk_int("full_acc1", acc[1] - acc[0], 1);
    chk_int("full_acc2", acc[2] - acc[0], 2);
    chk_int("full_acc3", acc[3] - acc[0], 3);
    chk_int("full_acc4", acc[4] - acc[0], 9);
    wait_drain(1);

    // 5: ADDR_OK_GAP=2, req held: accepts 3 cycles apart
    for (int k = 0; k < 3; k++)
      issue(2, 1'b1, 4'hF, 32'h40 + 32'(4 * k), 32'hC0DE_0000 + 32'(k), 32'h0, 1'b1, acc[k]);
    chk_int("gap_acc1", acc[1] - acc[0], 3);
    chk_int("gap_acc2", acc[2] - acc[0], 6);
    issue(2, 1'b0, 4'h0, 32'h44, 32'h0, 32'hC0DE_0001, 1'b1, a0);
    wait_drain(2);

    // 6: reset one cycle after two accepted reads drops them; array survives reset
    issue(3, 1'b1, 4'hF, 32'h40, 32'h0A0B0C0D, 32'h0, 1'b1, a0);
    wait_drain(3);
    issue(3, 1'b0, 4'h0, 32'h40, 32'h0, 32'h0, 1'b0, a0);
    issue(3, 1'b0, 4'h0, 32'h44, 32'h0, 32'h0, 1'b0, a1);
    chk_int("rst_b2b_accept", a1 - a0, 1);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_int("rst_mid_addr_ok", int'(aok_s[3]), 0);
      chk_int("rst_mid_data_ok", int'(dok_s[3]), 0);
      chk_int("rst_mid_rdata", int'(rdat_s[3]), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    issue(3, 1'b0, 4'h0, 32'h40, 32'h0, 32'h0A0B0C0D, 1'b1, a0);
    wait_drain(3);

    for (int i = 0; i < NI; i++) chk_int("leftover_resp", exp_q[i].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
